recipe_scheduler: RTL

- Queues RGB dispense recipes and sequences the three colour motors one channel at a time.
- A recipe is R, G, B tick counts captured from the keypad/RGB memory path.
- Sits between the RGB memory/keypad path and the Motores outputs.
- Takes over the timer/FSM sequencing role for batch operation: several recipes are entered, then run back to back.

---
 rtl/recipe_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/recipe_scheduler.sv
// Batch RGB recipe scheduler: a FIFO of {R,G,B} tick counts, drained one
// recipe at a time and one colour channel at a time onto the one-hot Motores outputs.
module recipe_scheduler #(
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned W        = 5,
    parameter  int unsigned TICK_DIV = 20,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  r_in,
    input  logic [W-1:0]  g_in,
    input  logic [W-1:0]  b_in,
    input  logic          start,
    input  logic          abort,
    output logic [2:0]    Motores,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          done
);

    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   DW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] TICK_LAST = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_R,
        RUN_G,
        RUN_B,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [3*W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    cur_r_q, cur_r_d;
    logic [W-1:0]    cur_g_q, cur_g_d;
    logic [W-1:0]    cur_b_q, cur_b_d;
    logic [DW-1:0]   presc_q, presc_d;
    logic [2:0]      motor_q, motor_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            pop;
    logic            push_ok;
    logic            tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_r_q  <= '0;
            cur_g_q  <= '0;
            cur_b_q  <= '0;
            presc_q  <= '0;
            motor_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_r_q  <= cur_r_d;
            cur_g_q  <= cur_g_d;
            cur_b_q  <= cur_b_d;
            presc_q  <= presc_d;
            motor_q  <= motor_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {r_in, g_in, b_in};
        end
    end

    // A RUN state stays one extra cycle once its count reaches zero; that
    // drain cycle drives no motor and gives the off-gap between channels.
    always_comb begin
        state_d = state_q;
        cur_r_d = cur_r_q;
        cur_g_d = cur_g_q;
        cur_b_d = cur_b_q;
        presc_d = '0;
        motor_d = '0;
        pop     = 1'b0;
        tick    = (presc_q == TICK_LAST);

        unique case (state_q)
            IDLE: begin
                if (start && (count_q != '0)) state_d = LOAD;
            end
            LOAD: begin
                pop = 1'b1;
                {cur_r_d, cur_g_d, cur_b_d} = mem_q[rd_ptr_q];
                state_d = RUN_R;
            end
            RUN_R: begin
                if (cur_r_q == '0) begin
                    state_d = RUN_G;
                end else begin
                    motor_d = 3'b100;
                    presc_d = tick ? '0 : presc_q + DW'(1);
                    if (tick) cur_r_d = cur_r_q - W'(1);
                end
            end
            RUN_G: begin
                if (cur_g_q == '0) begin
                    state_d = RUN_B;
                end else begin
                    motor_d = 3'b010;
                    presc_d = tick ? '0 : presc_q + DW'(1);
                    if (tick) cur_g_d = cur_g_q - W'(1);
                end
            end
            RUN_B: begin
                if (cur_b_q == '0) begin
                    state_d = FIN;
                end else begin
                    motor_d = 3'b001;
                    presc_d = tick ? '0 : presc_q + DW'(1);
                    if (tick) cur_b_d = cur_b_q - W'(1);
                end
            end
            FIN: begin
                state_d = ((count_q != '0) || push) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort in LOAD also cancels the pop so the head entry stays queued.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            motor_d = '0;
            presc_d = '0;
            pop     = 1'b0;
        end

        done_d = (state_d == FIN);
    end

    always_comb begin
        push_ok  = push && ((count_q != CNT_FULL) || pop);
        ovf_d    = push && !push_ok;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    assign Motores  = motor_q;
    assign busy     = (state_q != IDLE);
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign done     = done_q;

endmodule
